// File: rtl/conv_frame_ctrl_if.sv
// Read-side and write-side handshake pair observed by the frame sequencer.
// The datapath drives these signals (master); the sequencer only watches them (slave).
interface conv_frame_ctrl_if;
    logic read_valid;
    logic buf_ready;
    logic conv_valid;
    logic write_ready;

    modport master (
        output read_valid,
        output buf_ready,
        output conv_valid,
        output write_ready
    );

    modport slave (
        input read_valid,
        input buf_ready,
        input conv_valid,
        input write_ready
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolution chain: gates/clears the datapath, counts pixels
// per frame against the geometry, runs back-to-back frames and traps stalls/violations.
module conv_frame_ctrl #(
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int TIMEOUT     = 1024,
    localparam int IN_N  = WIDTH * HEIGHT,
    localparam int OUT_N = (WIDTH - KERNEL_SIZE + 1) * (HEIGHT - KERNEL_SIZE + 1),
    localparam int RW    = $clog2(IN_N + 1),
    localparam int WW    = $clog2(OUT_N + 1)
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    start,
    input  logic                    abort,
    input  logic [7:0]              frames_cfg,
    conv_frame_ctrl_if.slave        hs,
    output logic                    pipe_en,
    output logic                    pipe_clr,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [7:0]              frame_idx,
    output logic [RW-1:0]           rd_cnt,
    output logic [WW-1:0]           wr_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [RW-1:0] IN_C     = RW'(IN_N);
    localparam logic [WW-1:0] OUT_LAST = WW'(OUT_N - 1);
    localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);

    logic [2:0]    state, nxt;
    logic [7:0]    nframes;
    logic [TW-1:0] wd;
    logic          rd_fire, wr_fire, rd_full, rd_full_eff;
    logic          overread, frame_end, timeout_hit, cnt_en;

    always_comb begin
        rd_fire     = hs.read_valid & hs.buf_ready;
        wr_fire     = hs.conv_valid & hs.write_ready;
        rd_full     = (rd_cnt == IN_C);
        // input is complete if already full or the final pixel lands in this same cycle
        rd_full_eff = rd_full | (rd_fire & (rd_cnt == IN_C - RW'(1)));
        overread    = rd_fire & rd_full;
        frame_end   = wr_fire & (wr_cnt == OUT_LAST);
        timeout_hit = !rd_fire && !wr_fire && (wd == WD_LAST);

        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_CLEAR;
            S_CLEAR: nxt = S_RUN;
            S_RUN: begin
                if (overread || timeout_hit)
                    nxt = S_ERR;
                else if (frame_end)
                    nxt = !rd_full_eff                  ? S_ERR  :
                          (frame_idx < nframes - 8'd1)  ? S_NEXT : S_DONE;
            end
            S_NEXT:  nxt = S_CLEAR;
            S_DONE:  nxt = S_IDLE;
            S_ERR:   nxt = S_ERR;
            default: nxt = S_IDLE;
        endcase
        if (abort)
            nxt = S_IDLE;

        cnt_en = (state == S_RUN) &&
                 (nxt == S_RUN || nxt == S_NEXT || nxt == S_DONE);
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= S_IDLE;
            pipe_en   <= 1'b0;
            pipe_clr  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            nframes   <= 8'd1;
            frame_idx <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wd        <= '0;
        end else begin
            state    <= nxt;
            pipe_en  <= (nxt == S_RUN);
            pipe_clr <= (nxt == S_CLEAR);
            busy     <= (nxt != S_IDLE);
            done     <= (nxt == S_DONE);
            error    <= (nxt == S_ERR);

            if (state == S_IDLE && nxt == S_CLEAR) begin
                nframes   <= (frames_cfg == 8'd0) ? 8'd1 : frames_cfg;
                frame_idx <= '0;
            end else if (state == S_NEXT && nxt == S_CLEAR) begin
                frame_idx <= frame_idx + 8'd1;
            end

            if (nxt == S_CLEAR) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
                wd     <= '0;
            end else if (cnt_en) begin
                rd_cnt <= rd_cnt + RW'(rd_fire);
                wr_cnt <= wr_cnt + WW'(wr_fire);
                wd     <= (rd_fire || wr_fire) ? '0 : wd + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: directed frames push expected done/error events,
// an independent monitor pops and checks them when the DUT raises done or error.
module tb_conv_frame_ctrl;
    localparam int RW = 11;
    localparam int WW = 10;

    logic          clk = 1'b0;
    logic          rstb;
    logic          start, abort;
    logic [7:0]    frames_cfg;
    logic          pipe_en, pipe_clr, busy, done, error;
    logic [7:0]    frame_idx;
    logic [RW-1:0] rd_cnt;
    logic [WW-1:0] wr_cnt;

    conv_frame_ctrl_if hs();

    conv_frame_ctrl #(
        .WIDTH(32), .HEIGHT(32), .KERNEL_SIZE(3), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort), .frames_cfg(frames_cfg),
        .hs(hs), .pipe_en(pipe_en), .pipe_clr(pipe_clr), .busy(busy), .done(done),
        .error(error), .frame_idx(frame_idx), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = done pulse, 1 = error rise
        int idx;
        int rd;
        int wr;     // -1 = not compared
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   clr_cnt  = 0;
    logic err_prev = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rstb) begin
            err_prev = 1'b0;
        end else begin
            if (pipe_clr) clr_cnt++;
            if (done || (error && !err_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event done=%0d error=%0d required=none t=%0t",
                             done, error, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_kind", error ? 1 : 0, e.kind);
                    chk("event_frame_idx", int'(frame_idx), e.idx);
                    chk("event_rd_cnt", int'(rd_cnt), e.rd);
                    if (e.wr >= 0) chk("event_wr_cnt", int'(wr_cnt), e.wr);
                end
            end
            err_prev = error;
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_hs();
        hs.read_valid  = 1'b0;
        hs.buf_ready   = 1'b0;
        hs.conv_valid  = 1'b0;
        hs.write_ready = 1'b0;
    endtask

    // start pulse, then CLEAR for one cycle, then RUN
    task automatic start_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_pipe_clr", pipe_clr, 1);
        chk("clear_busy", busy, 1);
        chk("clear_pipe_en", pipe_en, 0);
        tick();
        chk("run_pipe_en", pipe_en, 1);
        chk("run_pipe_clr", pipe_clr, 0);
    endtask

    // Interleaves nrd reads with nwr-1 writes (some same-cycle, some valid-without-ready),
    // then issues the last write alone. Returns just after the frame-complete edge.
    task automatic drive_frame(input int nrd, input int nwr, input bit abort_last);
        int r = 0;
        int w = 0;
        int c = 0;
        while (r < nrd || w < nwr - 1) begin
            bit rf, wf;
            rf = (r < nrd) && (c % 5 != 4);
            wf = (w < nwr - 1) && (c % 2 == 1);
            hs.read_valid  = (r < nrd);
            hs.buf_ready   = rf;
            hs.conv_valid  = (w < nwr - 1);
            hs.write_ready = wf;
            tick();
            r += int'(rf);
            w += int'(wf);
            c++;
        end
        idle_hs();
        hs.conv_valid  = 1'b1;
        hs.write_ready = 1'b1;
        abort = abort_last;
        tick();
        abort = 1'b0;
        idle_hs();
    endtask

    initial begin
        rstb = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        frames_cfg = 8'd1;
        idle_hs();
        #23;
        chk("reset_pipe_en", pipe_en, 0);
        chk("reset_pipe_clr", pipe_clr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_counts", int'(frame_idx) + int'(rd_cnt) + int'(wr_cnt), 0);
        rstb = 1'b1;
        tick();

        // single frame
        exp_q.push_back('{0, 0, 1024, 900});
        start_seq();
        drive_frame(1024, 900, 0);
        chk("single_pipe_en_drop", pipe_en, 0);
        chk("single_done", done, 1);
        chk("single_busy_m1", busy, 1);
        chk("single_rd_cnt", int'(rd_cnt), 1024);
        chk("single_wr_cnt", int'(wr_cnt), 900);
        tick();
        chk("single_busy_m2", busy, 0);
        chk("single_done_once", done, 0);
        chk("single_error", error, 0);

        // three back-to-back frames
        frames_cfg = 8'd3;
        begin
            int clr_base;
            clr_base = clr_cnt;
            exp_q.push_back('{0, 2, 1024, 900});
            start_seq();
            for (int f = 0; f < 3; f++) begin
                chk("multi_frame_idx", int'(frame_idx), f);
                drive_frame(1024, 900, 0);
                chk("multi_pipe_en_drop", pipe_en, 0);
                if (f < 2) begin
                    chk("multi_no_early_done", done, 0);
                    tick();
                    chk("multi_pipe_clr", pipe_clr, 1);
                    chk("multi_clr_rd_cnt", int'(rd_cnt), 0);
                    tick();
                    chk("multi_rerun", pipe_en, 1);
                end
            end
            tick();
            chk("multi_busy_low", busy, 0);
            chk("multi_clr_pulses", clr_cnt - clr_base, 3);
        end

        // frames_cfg = 0 behaves as a single frame
        frames_cfg = 8'd0;
        exp_q.push_back('{0, 0, 1024, 900});
        start_seq();
        drive_frame(1024, 900, 0);
        chk("zero_cfg_done", done, 1);
        tick();
        chk("zero_cfg_busy_low", busy, 0);

        // premature output: last write with only 1000 pixels read
        frames_cfg = 8'd1;
        exp_q.push_back('{1, 0, 1000, -1});
        start_seq();
        drive_frame(1000, 900, 0);
        chk("premature_error", error, 1);
        chk("premature_pipe_en", pipe_en, 0);
        chk("premature_no_done", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_ignores_start", error, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_clears_error", error, 0);
        chk("abort_busy", busy, 0);

        // watchdog: 15 idle cycles tolerated, 16 trips it
        exp_q.push_back('{1, 0, 6, 0});
        start_seq();
        hs.read_valid = 1'b1;
        hs.buf_ready  = 1'b1;
        repeat (5) tick();
        idle_hs();
        repeat (15) tick();
        chk("wd_stall15_ok", error, 0);
        hs.read_valid = 1'b1;
        hs.buf_ready  = 1'b1;
        tick();
        idle_hs();
        chk("wd_after_fire_ok", error, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("wd_no_early_error", error, 0);
        end
        tick();
        chk("wd_error", error, 1);
        chk("wd_pipe_en", pipe_en, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // asynchronous reset mid-frame, then a clean frame
        start_seq();
        hs.read_valid = 1'b1;
        hs.buf_ready  = 1'b1;
        repeat (500) tick();
        idle_hs();
        chk("pre_reset_rd_cnt", int'(rd_cnt), 500);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_pipe_en", pipe_en, 0);
        chk("async_rst_rd_cnt", int'(rd_cnt), 0);
        chk("async_rst_flags", int'(done) + int'(error) + int'(pipe_clr), 0);
        tick();
        rstb = 1'b1;
        tick();
        exp_q.push_back('{0, 0, 1024, 900});
        start_seq();
        drive_frame(1024, 900, 0);
        tick();
        chk("post_reset_busy_low", busy, 0);

        // abort coincident with the frame-complete write
        start_seq();
        drive_frame(1024, 900, 1);
        chk("abort_complete_busy", busy, 0);
        chk("abort_complete_no_done", done, 0);
        chk("abort_complete_pipe_en", pipe_en, 0);
        chk("abort_complete_rd_hold", int'(rd_cnt), 1024);
        tick();
        chk("abort_complete_no_done2", done, 0);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
